ofifo_pipe: RTL

//  Parametrised output FIFO collecting per-column results from the systolic array (one independent

---
 rtl/ofifo_pkg.sv | 20 ++
 rtl/ofifo_lane.sv | 42 ++++
 rtl/ofifo_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared sizing and pointer-compare helpers for the output FIFO
package ofifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic is_empty(input logic [31:0] rp, input logic [31:0] wp);
        return rp == wp;
    endfunction

    // Pointers carry one extra wrap bit: full means same slot, opposite lap
    function automatic logic is_full(input logic [31:0] rp, input logic [31:0] wp, input int aw);
        return (rp ^ wp) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: one column circular buffer with wrap-bit pointers and occupancy
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  pop,
    input  logic [bw-1:0]         din,
    output logic [bw-1:0]         dout,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(depth):0] occ
);
    localparam int aw = clog2(depth);

    logic [bw-1:0] mem [depth];
    logic [aw:0]   rd_ptr, wr_ptr;
    logic          wr_ok;

    assign empty = is_empty(32'(rd_ptr), 32'(wr_ptr));
    assign full  = is_full(32'(rd_ptr), 32'(wr_ptr), aw);
    assign occ   = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[aw-1:0]];
    assign wr_ok = wr && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) if (wr_ok) mem[wr_ptr[aw-1:0]] <= din;

endmodule

// File: rtl/ofifo_pipe.sv
// ofifo_pipe: per-column output FIFO releasing complete rows through a registered read port
// Define OFIFO_PIPE_ERR_EN to add sticky o_ovf/o_udf error flags.
module ofifo_pipe
    import ofifo_pkg::*;
#(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [col*bw-1:0]     in,
    input  logic [col-1:0]        wr,
    input  logic                  rd,
    output logic [col*bw-1:0]     out,
    output logic                  o_rvalid,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_ready,
    output logic [clog2(depth):0] o_count
`ifdef OFIFO_PIPE_ERR_EN
    ,
    output logic                  o_ovf,
    output logic                  o_udf
`endif
);
    localparam int aw = clog2(depth);

    logic [col*bw-1:0] row;
    logic [col-1:0]    empty, full;
    logic [aw:0]       occ [col];
    logic              pop;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = !o_full;
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(.bw(bw), .depth(depth)) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .pop   (pop),
            .din   (in[i*bw +: bw]),
            .dout  (row[i*bw +: bw]),
            .empty (empty[i]),
            .full  (full[i]),
            .occ   (occ[i])
        );
    end

    // Complete rows are limited by the least-filled column
    always_comb begin
        o_count = occ[0];
        for (int i = 1; i < col; i++) o_count = occ[i] < o_count ? occ[i] : o_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= pop;
            if (pop) out <= row;
        end
    end

`ifdef OFIFO_PIPE_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            o_ovf <= o_ovf | (|(wr & full));
            o_udf <= o_udf | (rd && !o_valid);
        end
    end
`endif

endmodule
